// File: rtl/math_op_arbiter.sv
// Round-robin arbiter sharing one signed W-bit add/sub/mul/negate unit between two requesters.
// One operation is in flight at a time; tagged results return over a valid/ready channel.
module math_op_arbiter #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             req_valid_0,
    input  logic             req_valid_1,
    output logic             req_ready_0,
    output logic             req_ready_1,
    input  logic [1:0]       req_op_0,
    input  logic [1:0]       req_op_1,
    input  logic [W-1:0]     req_a_0,
    input  logic [W-1:0]     req_a_1,
    input  logic [W-1:0]     req_b_0,
    input  logic [W-1:0]     req_b_1,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [2*W-1:0]   rsp_data,
    output logic             rsp_ovf,
    output logic [15:0]      done_cnt
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q;
    logic             last_q;
    logic             id_q;
    logic [1:0]       op_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [2*W-1:0]   rsp_data_q;
    logic             rsp_ovf_q;
    logic [15:0]      done_cnt_q;

    logic             gnt_0;
    logic             gnt_1;
    logic [W:0]       a_x;
    logic [W:0]       b_x;
    logic [W:0]       sum_w;
    logic [2*W-1:0]   prod;
    logic [2*W-1:0]   res_d;
    logic             ovf_d;

    // On a tie the requester that was not served last wins; the two grants are exclusive.
    assign gnt_0 = req_valid_0 && (!req_valid_1 || last_q);
    assign gnt_1 = req_valid_1 && (!req_valid_0 || !last_q);

    assign req_ready_0 = n_rst && (state_q == IDLE) && gnt_0;
    assign req_ready_1 = n_rst && (state_q == IDLE) && gnt_1;

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_ovf   = rsp_ovf_q;
    assign done_cnt  = done_cnt_q;

    always_comb begin
        a_x   = {a_q[W-1], a_q};
        b_x   = {b_q[W-1], b_q};
        sum_w = '0;
        prod  = {{W{a_q[W-1]}}, a_q} * {{W{b_q[W-1]}}, b_q};
        case (op_q)
            2'b00:   sum_w = a_x + b_x;
            2'b01:   sum_w = a_x - b_x;
            2'b11:   sum_w = '0 - a_x;
            default: sum_w = '0;
        endcase
        if (op_q == 2'b10) begin
            res_d = prod;
            ovf_d = 1'b0;
        end else begin
            res_d = {{(W-1){sum_w[W]}}, sum_w};
            // Out of W-bit range exactly when the extra sign bit disagrees with the W-bit sign.
            ovf_d = sum_w[W] ^ sum_w[W-1];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            id_q        <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_ovf_q   <= 1'b0;
            done_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_0 || gnt_1) begin
                        id_q    <= gnt_1;
                        last_q  <= gnt_1;
                        op_q    <= gnt_1 ? req_op_1 : req_op_0;
                        a_q     <= gnt_1 ? req_a_1  : req_a_0;
                        b_q     <= gnt_1 ? req_b_1  : req_b_0;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data_q  <= res_d;
                    rsp_ovf_q   <= ovf_d;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        done_cnt_q  <= done_cnt_q + 16'd1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_math_op_arbiter.sv
// Scoreboard bench for math_op_arbiter: expectations are queued at each accepted request
// from an integer arithmetic model and compared as responses are consumed.
module tb_math_op_arbiter;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        req_valid_0, req_valid_1;
    logic        req_ready_0, req_ready_1;
    logic [1:0]  req_op_0, req_op_1;
    logic [7:0]  req_a_0, req_a_1, req_b_0, req_b_1;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_ovf;
    logic [15:0] rsp_data;
    logic [15:0] done_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int exp_done = 0;
    logic [17:0] sb_q[$];
    int          acc_q[$];

    math_op_arbiter #(.W(8)) dut (
        .clk(clk), .n_rst(n_rst),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .req_op_0(req_op_0), .req_op_1(req_op_1),
        .req_a_0(req_a_0), .req_a_1(req_a_1),
        .req_b_0(req_b_0), .req_b_1(req_b_1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ovf(rsp_ovf),
        .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {ovf, data[15:0]} from plain integer arithmetic
    function automatic logic [16:0] model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int sa, sb, r;
        logic ovf;
        logic [31:0] rr;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (op)
            2'd0:    r = sa + sb;
            2'd1:    r = sa - sb;
            2'd2:    r = sa * sb;
            default: r = -sa;
        endcase
        ovf = (op != 2'd2) && (r < -128 || r > 127);
        rr  = r;
        return {ovf, rr[15:0]};
    endfunction

    always @(negedge clk) begin
        if (req_ready_0) begin
            sb_q.push_back({1'b0, model(req_op_0, req_a_0, req_b_0)});
            acc_q.push_back(cyc);
        end
        if (req_ready_1) begin
            sb_q.push_back({1'b1, model(req_op_1, req_a_1, req_b_1)});
            acc_q.push_back(cyc);
        end
    end

    always @(negedge clk) begin
        logic [17:0] e;
        if (rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("rsp_id",   rsp_id,   e[17]);
                chk("rsp_ovf",  rsp_ovf,  e[16]);
                chk("rsp_data", rsp_data, e[15:0]);
                exp_done++;
            end
        end
    end

    // Present a request, wait for acceptance, then check the one-cycle EXEC latency.
    task automatic issue(input int idx, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        bit got = 0;
        @(posedge clk); #1;
        if (idx == 0) begin
            req_op_0 = op; req_a_0 = a; req_b_0 = b; req_valid_0 = 1'b1;
        end else begin
            req_op_1 = op; req_a_1 = a; req_b_1 = b; req_valid_1 = 1'b1;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if ((idx == 0 && req_ready_0) || (idx == 1 && req_ready_1)) got = 1;
        end
        if (!got) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        if (idx == 0) req_valid_0 = 1'b0; else req_valid_1 = 1'b0;
        @(negedge clk);
        chk("lat_exec_valid", rsp_valid, 1'b0);
        @(negedge clk);
        chk("lat_resp_valid", rsp_valid, 1'b1);
    endtask

    task automatic wait_idle();
        bit idle = 0;
        for (int i = 0; i < 20 && !idle; i++) begin
            @(negedge clk);
            if (!rsp_valid) idle = 1;
        end
        if (!idle) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int n_rr;
        bit stop;
        n_rst = 1'b0;
        rsp_ready = 1'b1;
        req_valid_0 = 1'b1; req_valid_1 = 1'b1;
        req_op_0 = 2'd0; req_op_1 = 2'd0;
        req_a_0 = 8'd1; req_b_0 = 8'd2; req_a_1 = 8'd3; req_b_1 = 8'd4;

        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_id",    rsp_id,    1'b0);
        chk("rst_rsp_data",  rsp_data,  16'h0000);
        chk("rst_rsp_ovf",   rsp_ovf,   1'b0);
        chk("rst_done_cnt",  done_cnt,  16'd0);
        chk("rst_ready_0",   req_ready_0, 1'b0);
        chk("rst_ready_1",   req_ready_1, 1'b0);
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        @(posedge clk); #1 n_rst = 1'b1;

        issue(0, 2'd2, 8'h80, 8'h80);  wait_idle();
        issue(1, 2'd1, 8'h80, 8'h01);  wait_idle();
        issue(0, 2'd0, 8'd127, 8'd1);  wait_idle();
        issue(0, 2'd3, 8'h80, 8'h00);  wait_idle();
        issue(0, 2'd3, 8'd5, 8'h00);   wait_idle();
        for (int i = 0; i < 10; i++) begin
            issue(int'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            wait_idle();
        end
        repeat (2) @(negedge clk);
        chk("directed_done_cnt", done_cnt, 16'd15);
        chk("directed_sb_empty", sb_q.size(), 32'd0);

        // Fairness: both requesters valid straight out of reset.
        @(posedge clk); #1;
        n_rst = 1'b0;
        sb_q.delete(); acc_q.delete(); exp_done = 0;
        req_op_0 = 2'd0; req_a_0 = 8'd1; req_b_0 = 8'd2;
        req_op_1 = 2'd0; req_a_1 = 8'd3; req_b_1 = 8'd4;
        req_valid_0 = 1'b1; req_valid_1 = 1'b1;
        @(posedge clk); #1 n_rst = 1'b1;
        n_rr = 0;
        stop = 0;
        for (int i = 0; i < 100 && !stop; i++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                chk("rr_id",   rsp_id,   n_rr % 2);
                chk("rr_data", rsp_data, (n_rr % 2) ? 16'd7 : 16'd3);
                n_rr++;
                if (n_rr == 6) stop = 1;
            end
        end
        if (!stop) chk("rr_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rr_acc_count", acc_q.size(), 32'd6);
        for (int i = 1; i < acc_q.size(); i++)
            chk("rr_acc_spacing", acc_q[i] - acc_q[i-1], 32'd3);
        chk("rr_done_cnt", done_cnt, 16'd6);

        // Backpressure in RESP.
        rsp_ready = 1'b0;
        issue(1, 2'd0, 8'h10, 8'h20);
        @(posedge clk); #1;
        req_op_0 = 2'd0; req_a_0 = 8'd9; req_b_0 = 8'd9; req_valid_0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid",   rsp_valid,   1'b1);
            chk("bp_data",    rsp_data,    16'h0030);
            chk("bp_id",      rsp_id,      1'b1);
            chk("bp_ovf",     rsp_ovf,     1'b0);
            chk("bp_ready_0", req_ready_0, 1'b0);
            chk("bp_ready_1", req_ready_1, 1'b0);
            chk("bp_done",    done_cnt,    16'd6);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_valid", rsp_valid,   1'b0);
        chk("bp_release_idle",  req_ready_0, 1'b1);
        @(posedge clk); #1 req_valid_0 = 1'b0;
        @(negedge clk);
        wait_idle();
        @(negedge clk);
        chk("bp_done_after", done_cnt, 16'd8);

        // Reset while in EXEC discards the operation.
        @(posedge clk); #1;
        req_op_0 = 2'd0; req_a_0 = 8'd1; req_b_0 = 8'd1; req_valid_0 = 1'b1;
        stop = 0;
        for (int i = 0; i < 20 && !stop; i++) begin
            @(negedge clk);
            if (req_ready_0) stop = 1;
        end
        if (!stop) chk("exec_rst_accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        n_rst = 1'b0;
        req_valid_1 = 1'b1;
        sb_q.delete();
        #1;
        chk("exec_rst_valid", rsp_valid, 1'b0);
        chk("exec_rst_done",  done_cnt,  16'd0);
        chk("exec_rst_data",  rsp_data,  16'h0000);
        chk("exec_rst_rdy0",  req_ready_0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("exec_rst_no_rsp", rsp_valid, 1'b0);
        end
        @(posedge clk); #1 n_rst = 1'b1;
        @(negedge clk);
        chk("post_rst_grant0", req_ready_0, 1'b1);
        chk("post_rst_grant1", req_ready_1, 1'b0);
        @(posedge clk); #1;
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        @(negedge clk);
        wait_idle();
        @(negedge clk);
        chk("post_rst_done", done_cnt, 16'd1);
        chk("final_sb_empty", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
